// File: rtl/rs232_txq.sv
// Byte transmit queue feeding the RS232 transmitter via its start/data/rdy handshake.
// Optional occupancy output enabled by defining RS232_TXQ_LEVEL_EN.
module rs232_txq #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr,
   input  logic [7:0]          wdata,
   input  logic                clr_ovf,
   output logic                full,
   output logic                empty,
   output logic                idle,
   output logic                ovf,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_rdy
`ifdef RS232_TXQ_LEVEL_EN
   ,
   output logic [DEPTH_LOG2:0] level
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_GUARD,
      S_WAIT
   } state_t;

   state_t              state_reg;
   logic [DEPTH_LOG2:0] wr_ptr_reg;
   logic [DEPTH_LOG2:0] rd_ptr_reg;
   logic [7:0]          mem [DEPTH];
   logic [7:0]          tx_data_reg;
   logic                tx_start_reg;
   logic                ovf_reg;
   logic                push;
   logic                pop;

   // Extra wrap bit distinguishes full (MSB differs) from empty (identical).
   assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                  (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign push  = wr & ~full;
   assign pop   = (state_reg == S_IDLE) & ~empty & tx_rdy;
   assign idle  = empty & (state_reg == S_IDLE) & tx_rdy;

   assign ovf      = ovf_reg;
   assign tx_start = tx_start_reg;
   assign tx_data  = tx_data_reg;

`ifdef RS232_TXQ_LEVEL_EN
   assign level = wr_ptr_reg - rd_ptr_reg;
`endif

   // Storage kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         tx_data_reg  <= 8'h00;
         tx_start_reg <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end

         if (wr & full) begin
            ovf_reg <= 1'b1;
         end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
         end

         // GUARD skips one cycle because the transmitter drops rdy a cycle late.
         case (state_reg)
            S_IDLE: begin
               if (pop) begin
                  state_reg    <= S_START;
                  tx_start_reg <= 1'b1;
                  tx_data_reg  <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
                  rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
               end
            end
            S_START: begin
               tx_start_reg <= 1'b0;
               state_reg    <= S_GUARD;
            end
            S_GUARD: begin
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_rdy) begin
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               tx_start_reg <= 1'b0;
               state_reg    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_txq.sv
// Directed bench for rs232_txq with a simple transmitter model that goes busy
// for 20 cycles, starting one cycle after each tx_start.
module tb_rs232_txq;

   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       wr      = 1'b0;
   logic [7:0] wdata   = 8'h00;
   logic       clr_ovf = 1'b0;
   logic       full;
   logic       empty;
   logic       idle;
   logic       ovf;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_rdy;
`ifdef RS232_TXQ_LEVEL_EN
   logic [DL:0] level;
`endif

   logic force_busy = 1'b0;
   int   busy_cnt   = 0;
   int   cyc        = 0;
   int   pass_cnt   = 0;
   int   chk_cnt    = 0;

   logic [7:0] start_data[$];
   int         start_cyc[$];
   int         start_gap[$];
   int         bad_start = 0;
   int         rise_cyc  = 0;
   logic       prev_rdy  = 1'b1;

   rs232_txq #(.DEPTH_LOG2(DL)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .wdata    (wdata),
      .clr_ovf  (clr_ovf),
      .full     (full),
      .empty    (empty),
      .idle     (idle),
      .ovf      (ovf),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_rdy   (tx_rdy)
`ifdef RS232_TXQ_LEVEL_EN
      ,
      .level    (level)
`endif
   );

   always #20 clk = ~clk;

   assign tx_rdy = !force_busy && (busy_cnt == 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_start) busy_cnt <= 20;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   // Log every start pulse with its distance from the latest tx_rdy rise.
   always @(negedge clk) begin
      if (tx_rdy && !prev_rdy) rise_cyc = cyc;
      prev_rdy = tx_rdy;
      if (tx_start) begin
         start_data.push_back(tx_data);
         start_cyc.push_back(cyc);
         start_gap.push_back(cyc - rise_cyc);
         if (!tx_rdy) bad_start++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      start_data.delete();
      start_cyc.delete();
      start_gap.delete();
      bad_start = 0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      for (int i = 0; i < budget && start_data.size() < n; i++) step();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && !(idle && busy_cnt == 0); i++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      sample();
      chk_cnt++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      chk_cnt++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else pass_cnt++;
      chk_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else pass_cnt++;
      chk_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
`ifdef RS232_TXQ_LEVEL_EN
      chk_cnt++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
`endif
      $display("test_reset done");
   endtask

   task automatic test_single();
      int w;
      clear_log();
      step();
      wr = 1'b1; wdata = 8'hA5; w = cyc;
      step();
      wr = 1'b0;
      sample();
      chk_cnt++; if (empty !== 1'b0) $display("FAIL single_empty_c1: got %b want 0", empty); else pass_cnt++;
      chk_cnt++; if (tx_start !== 1'b0) $display("FAIL single_nostart_c1: got %b want 0", tx_start); else pass_cnt++;
      step();
      sample();
      chk_cnt++; if (tx_start !== 1'b1) $display("FAIL single_start_c2: got %b want 1", tx_start); else pass_cnt++;
      chk_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b1) $display("FAIL single_empty_after_pop: got %b want 1", empty); else pass_cnt++;
      step();
      sample();
      chk_cnt++; if (tx_start !== 1'b0) $display("FAIL single_start_c3: got %b want 0", tx_start); else pass_cnt++;
      chk_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_data_hold: got %h want a5", tx_data); else pass_cnt++;
      wait_idle(100);
      chk_cnt++; if (start_data.size() !== 1) $display("FAIL single_count: got %0d want 1", start_data.size()); else pass_cnt++;
      chk_cnt++;
      if ((start_cyc.size() > 0 ? start_cyc[0] : -1) !== w + 2)
         $display("FAIL single_latency: got cycle %0d want %0d", (start_cyc.size() > 0 ? start_cyc[0] : -1), w + 2);
      else pass_cnt++;
      $display("test_single done: starts=%0d", start_data.size());
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      clear_log();
      step();
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; wdata = 8'(i + 1);
         step();
      end
      wr = 1'b0;
      wait_starts(3, 300);
      chk_cnt++; if (start_data.size() !== 3) $display("FAIL b2b_count: got %0d want 3", start_data.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         exp = 8'(i + 1);
         chk_cnt++;
         if ((start_data.size() > i ? start_data[i] : 8'hxx) !== exp)
            $display("FAIL b2b_data%0d: got %h want %h", i, (start_data.size() > i ? start_data[i] : 8'hxx), exp);
         else pass_cnt++;
      end
      for (int i = 1; i < 3; i++) begin
         chk_cnt++;
         if ((start_gap.size() > i ? start_gap[i] : -1) !== 2)
            $display("FAIL b2b_gap%0d: got %0d want 2", i, (start_gap.size() > i ? start_gap[i] : -1));
         else pass_cnt++;
      end
      chk_cnt++; if (bad_start !== 0) $display("FAIL b2b_start_while_busy: got %0d want 0", bad_start); else pass_cnt++;
      wait_idle(100);
      $display("test_back_to_back done: starts=%0d", start_data.size());
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      clear_log();
      force_busy = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; wdata = 8'(8'h10 + i);
         step();
      end
      wr = 1'b0;
      sample();
      chk_cnt++; if (full !== 1'b1) $display("FAIL ovf_full16: got %b want 1", full); else pass_cnt++;
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_before_drop: got %b want 0", ovf); else pass_cnt++;
`ifdef RS232_TXQ_LEVEL_EN
      chk_cnt++; if (level !== 5'd16) $display("FAIL ovf_level16: got %0d want 16", level); else pass_cnt++;
`endif
      step();
      wr = 1'b1; wdata = 8'hEE;
      step();
      wr = 1'b0;
      sample();
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else pass_cnt++;
      chk_cnt++; if (full !== 1'b1) $display("FAIL ovf_still_full: got %b want 1", full); else pass_cnt++;
      step();
      wr = 1'b1; wdata = 8'hEF; clr_ovf = 1'b1;
      step();
      wr = 1'b0; clr_ovf = 1'b0;
      sample();
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b want 1", ovf); else pass_cnt++;
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      sample();
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", ovf); else pass_cnt++;
      chk_cnt++; if (start_data.size() !== 0) $display("FAIL ovf_no_start_busy: got %0d want 0", start_data.size()); else pass_cnt++;
      step();
      force_busy = 1'b0;
      wait_starts(DEPTH, DEPTH * 30);
      wait_idle(100);
      chk_cnt++; if (start_data.size() !== DEPTH) $display("FAIL ovf_drain_count: got %0d want 16", start_data.size()); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         exp = 8'(8'h10 + i);
         chk_cnt++;
         if ((start_data.size() > i ? start_data[i] : 8'hxx) !== exp)
            $display("FAIL ovf_drain%0d: got %h want %h", i, (start_data.size() > i ? start_data[i] : 8'hxx), exp);
         else pass_cnt++;
      end
      // Second fill runs with pointers carrying the wrap bit.
      clear_log();
      force_busy = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; wdata = 8'(8'h40 + i);
         step();
      end
      wr = 1'b0;
      sample();
      chk_cnt++; if (full !== 1'b1) $display("FAIL wrap_full: got %b want 1", full); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b0) $display("FAIL wrap_empty: got %b want 0", empty); else pass_cnt++;
      step();
      force_busy = 1'b0;
      wait_starts(DEPTH, DEPTH * 30);
      wait_idle(100);
      chk_cnt++; if (start_data.size() !== DEPTH) $display("FAIL wrap_drain_count: got %0d want 16", start_data.size()); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         exp = 8'(8'h40 + i);
         chk_cnt++;
         if ((start_data.size() > i ? start_data[i] : 8'hxx) !== exp)
            $display("FAIL wrap_drain%0d: got %h want %h", i, (start_data.size() > i ? start_data[i] : 8'hxx), exp);
         else pass_cnt++;
      end
      $display("test_overflow done: starts=%0d", start_data.size());
   endtask

   task automatic test_full_pop();
      clear_log();
      force_busy = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; wdata = 8'(8'h60 + i);
         step();
      end
      wr = 1'b0;
      // Release the transmitter and write in the same cycle: pop happens, write drops.
      force_busy = 1'b0; wr = 1'b1; wdata = 8'hDD;
      step();
      wr = 1'b0;
      sample();
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL fullpop_ovf: got %b want 1", ovf); else pass_cnt++;
      chk_cnt++; if (full !== 1'b0) $display("FAIL fullpop_full: got %b want 0", full); else pass_cnt++;
      chk_cnt++; if (tx_start !== 1'b1) $display("FAIL fullpop_start: got %b want 1", tx_start); else pass_cnt++;
      chk_cnt++; if (tx_data !== 8'h60) $display("FAIL fullpop_data: got %h want 60", tx_data); else pass_cnt++;
`ifdef RS232_TXQ_LEVEL_EN
      chk_cnt++; if (level !== 5'd15) $display("FAIL fullpop_level: got %0d want 15", level); else pass_cnt++;
`endif
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      wait_starts(DEPTH + 1, DEPTH * 30);
      wait_idle(100);
      chk_cnt++; if (start_data.size() !== DEPTH) $display("FAIL fullpop_count: got %0d want 16", start_data.size()); else pass_cnt++;
      chk_cnt++;
      if ((start_data.size() > 15 ? start_data[15] : 8'hxx) !== 8'h6F)
         $display("FAIL fullpop_last: got %h want 6f", (start_data.size() > 15 ? start_data[15] : 8'hxx));
      else pass_cnt++;
      $display("test_full_pop done: starts=%0d", start_data.size());
   endtask

   task automatic test_reset_mid();
      clear_log();
      step();
      for (int i = 0; i < 6; i++) begin
         wr = 1'b1; wdata = 8'(8'h80 + i);
         step();
      end
      wr = 1'b0;
      sample();
      chk_cnt++; if (empty !== 1'b0) $display("FAIL rstmid_queued: got empty=%b want 0", empty); else pass_cnt++;
`ifdef RS232_TXQ_LEVEL_EN
      chk_cnt++; if (level !== 5'd5) $display("FAIL rstmid_level: got %0d want 5", level); else pass_cnt++;
`endif
      #5;
      rst = 1'b1;
      #1;
      chk_cnt++; if (tx_start !== 1'b0) $display("FAIL rstmid_start: got %b want 0", tx_start); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b1) $display("FAIL rstmid_empty: got %b want 1", empty); else pass_cnt++;
      chk_cnt++; if (tx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", tx_data); else pass_cnt++;
      step();
      rst = 1'b0;
      repeat (80) step();
      sample();
      chk_cnt++; if (start_data.size() !== 1) $display("FAIL rstmid_no_more_starts: got %0d want 1", start_data.size()); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b1) $display("FAIL rstmid_empty_after: got %b want 1", empty); else pass_cnt++;
      $display("test_reset_mid done: starts=%0d", start_data.size());
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
